// File: rtl/y86_pkg.sv
// y86_pkg -- definitions shared between the boot loader and the Y86-64 pipeline.
//   loader_state_t : states of the instruction-memory loader FSM (3-bit encoding)
//   LOADER_ADDR_W  : instruction-memory byte-address width (capacity 2^LOADER_ADDR_W)
//   stat_t         : pipeline status codes
package y86_pkg;

  localparam int LOADER_ADDR_W = 10;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } loader_state_t;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream handshake into the loader plus the loader's
// instruction-memory write port.
//   in_valid/in_data/in_ready : valid/ready byte stream (source -> loader)
//   imem_wEn/imem_addr/imem_wdata : registered write port (loader -> imem)
// Modports: master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_wEn;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_wEn, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_wEn, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- boot-time program loader for the Y86-64 instruction memory.
// Accepts a frame LEN_LO, LEN_HI, N payload bytes, CHK (XOR of payload) and
// writes the payload from address 0. The pipeline is held in reset (cpu_run=0)
// until a frame with a legal length and matching checksum has been written.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   bus      : stream handshake in, instruction-memory write port out
//   reload   : one-cycle pulse, restarts loading from RUN or ERR
//   cpu_run  : pipeline may run
//   load_err : sticky error (bad length or bad checksum)
//   byte_cnt : payload bytes written so far
module imem_loader
  import y86_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.master   bus,
  input  logic            reload,
  output logic            cpu_run,
  output logic            load_err,
  output logic [ADDR_W:0] byte_cnt
);

  localparam logic [16:0] MEM_BYTES = 17'd1 << ADDR_W;

  loader_state_t     state_reg, state_next;
  logic [7:0]        len_lo_reg, len_lo_next;
  logic [15:0]       len_reg, len_next;
  logic [7:0]        acc_reg, acc_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [7:0]        wdata_reg, wdata_next;

  logic              take;
  logic [15:0]       len_hdr;
  logic [ADDR_W:0]   cnt_inc;

  // Ready is a pure function of state so the source never sees a
  // combinational path from in_valid back to in_ready.
  assign bus.in_ready = (state_reg == HDR_LO) || (state_reg == HDR_HI) ||
                        (state_reg == DATA)   || (state_reg == CHK);
  assign take     = bus.in_valid && bus.in_ready;
  assign len_hdr  = {bus.in_data, len_lo_reg};
  assign cnt_inc  = cnt_reg + {{ADDR_W{1'b0}}, 1'b1};

  assign cpu_run        = (state_reg == RUN);
  assign load_err       = (state_reg == ERR);
  assign byte_cnt       = cnt_reg;
  assign bus.imem_wEn   = wen_reg;
  assign bus.imem_addr  = waddr_reg;
  assign bus.imem_wdata = wdata_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= HDR_LO;
      len_lo_reg <= '0;
      len_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      wen_reg    <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      len_lo_reg <= len_lo_next;
      len_reg    <= len_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      wen_reg    <= wen_next;
      waddr_reg  <= waddr_next;
      wdata_reg  <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    len_lo_next = len_lo_reg;
    len_next    = len_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    wen_next    = 1'b0;      // strobe is a single-cycle pulse per payload byte
    waddr_next  = waddr_reg;
    wdata_next  = wdata_reg;

    case (state_reg)
      HDR_LO: begin
        if (take) begin
          len_lo_next = bus.in_data;
          state_next  = HDR_HI;
        end
      end
      HDR_HI: begin
        if (take) begin
          len_next = len_hdr;
          // A length above capacity would wrap the address; reject it here so
          // the DATA state never needs its own bound check.
          if ((len_hdr == 16'd0) || ({1'b0, len_hdr} > MEM_BYTES)) begin
            state_next = ERR;
          end else begin
            acc_next   = '0;
            cnt_next   = '0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (take) begin
          wen_next   = 1'b1;
          waddr_next = cnt_reg[ADDR_W-1:0];
          wdata_next = bus.in_data;
          acc_next   = acc_reg ^ bus.in_data;
          cnt_next   = cnt_inc;
          if (16'(cnt_inc) == len_reg) begin
            state_next = CHK;
          end
        end
      end
      CHK: begin
        if (take) begin
          state_next = (bus.in_data == acc_reg) ? RUN : ERR;
        end
      end
      RUN, ERR: begin
        if (reload) begin
          cnt_next   = '0;
          state_next = HDR_LO;
        end
      end
      default: begin
        state_next = HDR_LO;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed-vector bench for imem_loader.
// A monitor logs every instruction-memory write (address, data, cycle) and the
// stimulus thread compares the log and the status outputs against
// hand-computed values. Good-image checksum: 0x30^0xF2^0x10 = 0xD2.
module tb_imem_loader;
  import y86_pkg::*;

  localparam int ADDR_W = 10;

  logic            clk;
  logic            rst;
  logic            reload;
  logic            cpu_run;
  logic            load_err;
  logic [ADDR_W:0] byte_cnt;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .reload   (reload),
    .cpu_run  (cpu_run),
    .load_err (load_err),
    .byte_cnt (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // write log, filled at the negedge (mid-cycle) whenever the strobe is high
  logic [ADDR_W-1:0] wr_addr[$];
  logic [7:0]        wr_data[$];
  int                wr_cyc[$];

  always @(negedge clk) begin
    if (bus.imem_wEn === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Offer each byte for one cycle; with gaps, idle cycles precede each byte.
  // Returns at the negedge after the last transfer edge with in_valid low.
  task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps) begin
        int n;
        n = 1 + int'($urandom_range(0, 2));
        for (int g = 0; g < n; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, ".wEn"},      32'(bus.imem_wEn), 32'd0);
    check_eq({tag, ".addr"},     32'(bus.imem_addr), 32'd0);
    check_eq({tag, ".wdata"},    32'(bus.imem_wdata), 32'd0);
    check_eq({tag, ".cpu_run"},  32'(cpu_run), 32'd0);
    check_eq({tag, ".load_err"}, 32'(load_err), 32'd0);
    check_eq({tag, ".byte_cnt"}, 32'(byte_cnt), 32'd0);
  endtask

  task automatic check_good_writes(input string tag, input bit consecutive);
    check_eq({tag, ".nwr"}, 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check_eq({tag, ".a0"}, 32'(wr_addr[0]), 32'h0);
      check_eq({tag, ".d0"}, 32'(wr_data[0]), 32'h30);
      check_eq({tag, ".a1"}, 32'(wr_addr[1]), 32'h1);
      check_eq({tag, ".d1"}, 32'(wr_data[1]), 32'hF2);
      check_eq({tag, ".a2"}, 32'(wr_addr[2]), 32'h2);
      check_eq({tag, ".d2"}, 32'(wr_data[2]), 32'h10);
      if (consecutive) begin
        check_eq({tag, ".gap01"}, 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
        check_eq({tag, ".gap12"}, 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
      end
    end
  endtask

  initial begin
    logic [7:0] fr[$];

    rst          = 1'b0;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // good image, back to back
    clear_log();
    fr = '{8'h03, 8'h00, 8'h30, 8'hF2, 8'h10, 8'hD2};
    send_frame(fr, 1'b0);
    check_good_writes("good", 1'b1);
    check_eq("good.cpu_run",  32'(cpu_run), 32'd1);
    check_eq("good.load_err", 32'(load_err), 32'd0);
    check_eq("good.byte_cnt", 32'(byte_cnt), 32'd3);
    check_eq("good.in_ready", 32'(bus.in_ready), 32'd0);

    // reload from RUN, then a one-byte image
    pulse_reload();
    check_eq("reload.cpu_run",  32'(cpu_run), 32'd0);
    check_eq("reload.byte_cnt", 32'(byte_cnt), 32'd0);
    check_eq("reload.in_ready", 32'(bus.in_ready), 32'd1);
    clear_log();
    fr = '{8'h01, 8'h00, 8'h77, 8'h77};
    send_frame(fr, 1'b0);
    check_eq("reload.nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check_eq("reload.a0", 32'(wr_addr[0]), 32'h0);
      check_eq("reload.d0", 32'(wr_data[0]), 32'h77);
    end
    check_eq("reload.cpu_run_after", 32'(cpu_run), 32'd1);

    // bad checksum (correct would be 0xFF)
    pulse_reload();
    clear_log();
    fr = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
    send_frame(fr, 1'b0);
    check_eq("badchk.nwr",      32'(wr_addr.size()), 32'd2);
    check_eq("badchk.load_err", 32'(load_err), 32'd1);
    check_eq("badchk.cpu_run",  32'(cpu_run), 32'd0);
    check_eq("badchk.in_ready", 32'(bus.in_ready), 32'd0);

    // reload coincident with an offered byte: the byte must not be taken,
    // so the following 00 00 header is seen as N=0
    @(negedge clk);
    reload       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    @(negedge clk);
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("coinc.load_err", 32'(load_err), 32'd0);
    clear_log();
    fr = '{8'h00, 8'h00};
    send_frame(fr, 1'b0);
    check_eq("len0.load_err", 32'(load_err), 32'd1);
    check_eq("len0.nwr",      32'(wr_addr.size()), 32'd0);

    // N = 1025 rejected
    pulse_reload();
    clear_log();
    fr = '{8'h01, 8'h04};
    send_frame(fr, 1'b0);
    check_eq("len1025.load_err", 32'(load_err), 32'd1);
    check_eq("len1025.nwr",      32'(wr_addr.size()), 32'd0);

    // N = 1024 fills memory; payload i&0xFF, XOR over four 0..255 runs is 0
    pulse_reload();
    clear_log();
    fr = '{8'h00, 8'h04};
    for (int i = 0; i < 1024; i++) fr.push_back(8'(i));
    fr.push_back(8'h00);
    send_frame(fr, 1'b0);
    check_eq("len1024.nwr",      32'(wr_addr.size()), 32'd1024);
    if (wr_addr.size() == 1024) begin
      check_eq("len1024.alast", 32'(wr_addr[1023]), 32'h3FF);
      check_eq("len1024.dlast", 32'(wr_data[1023]), 32'hFF);
      check_eq("len1024.a511",  32'(wr_addr[511]), 32'h1FF);
    end
    check_eq("len1024.cpu_run",  32'(cpu_run), 32'd1);
    check_eq("len1024.byte_cnt", 32'(byte_cnt), 32'd1024);

    // gapped good image
    pulse_reload();
    clear_log();
    fr = '{8'h03, 8'h00, 8'h30, 8'hF2, 8'h10, 8'hD2};
    send_frame(fr, 1'b1);
    check_good_writes("gap", 1'b0);
    check_eq("gap.cpu_run",  32'(cpu_run), 32'd1);
    check_eq("gap.byte_cnt", 32'(byte_cnt), 32'd3);

    // reset after two of three payload bytes
    pulse_reload();
    fr = '{8'h03, 8'h00, 8'h30, 8'hF2};
    send_frame(fr, 1'b0);
    check_eq("midrst.wEn_inflight", 32'(bus.imem_wEn), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b1;
    clear_log();
    fr = '{8'h03, 8'h00, 8'h30, 8'hF2, 8'h10, 8'hD2};
    send_frame(fr, 1'b0);
    check_good_writes("resend", 1'b1);
    check_eq("resend.cpu_run", 32'(cpu_run), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
